// File: rtl/seven_segment_pkg.sv
// Shared types, glyph table and polarity helpers for the seven-segment mux.
package seven_segment_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-high gfedcba patterns for hex digits 0..F (bit0 = segment a).
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

  // Map an active-high segment pattern onto the board's pin polarity.
  function automatic logic [6:0] seg_on(input logic [6:0] lit, input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

  function automatic logic [6:0] seg_off(input logic active_low);
    return seg_on(7'h00, active_low);
  endfunction

endpackage

// File: rtl/seven_segment_scan_timer.sv
// Scan sequencer: slot/dead-time counter, digit index and frame-boundary pulse.
// Exposes next-state values so the top can register its outputs on the same
// edge on which the scan state and index change.
module seven_segment_scan_timer
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_CYCLES = 50000,
  parameter int DEAD_CYCLES    = 4,
  parameter int INDEX_WIDTH    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output scan_state_t            next_state,
  output logic [INDEX_WIDTH-1:0] next_index,
  output logic                   frame_boundary
);

  localparam int SLOT_MAX    = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
  localparam int COUNT_WIDTH = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

  localparam logic [COUNT_WIDTH-1:0] DRIVE_LAST = COUNT_WIDTH'(REFRESH_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] DEAD_LAST  =
    (DEAD_CYCLES > 0) ? COUNT_WIDTH'(DEAD_CYCLES - 1) : '0;
  localparam logic [INDEX_WIDTH-1:0] LAST_DIGIT = INDEX_WIDTH'(NUM_DIGITS - 1);

  scan_state_t            state;
  logic [INDEX_WIDTH-1:0] index;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] next_count;
  logic [INDEX_WIDTH-1:0] advanced_index;
  logic                   enter_drive;

  // Next-slot decision: count out the current slot, then move to blank or the next digit.
  always_comb begin
    advanced_index = (index == LAST_DIGIT) ? '0 : index + 1'b1;
    next_state     = state;
    next_index     = index;
    next_count     = count + 1'b1;
    enter_drive    = 1'b0;
    case (state)
      DRIVE: begin
        if (count == DRIVE_LAST) begin
          next_count = '0;
          if (DEAD_CYCLES == 0) begin
            next_index  = advanced_index;
            enter_drive = 1'b1;
          end else begin
            next_state = BLANK;
          end
        end
      end
      BLANK: begin
        if ((DEAD_CYCLES == 0) || (count == DEAD_LAST)) begin
          next_count  = '0;
          next_state  = DRIVE;
          next_index  = advanced_index;
          enter_drive = 1'b1;
        end
      end
      default: begin
        next_state = BLANK;
        next_count = '0;
      end
    endcase
    frame_boundary = enter_drive && (next_index == '0);
  end

  // Scan registers; reset parks on the last digit in BLANK so the first drive is digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      index <= LAST_DIGIT;
      count <= '0;
    end else begin
      state <= next_state;
      index <= next_index;
      count <= next_count;
    end
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed hex display driver with frame-synchronous value load,
// leading-zero blanking and per-digit blinking. All outputs are registered.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_CYCLES = 50000,
  parameter int DEAD_CYCLES    = 4,
  parameter int BLINK_CYCLES   = 25000000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int EN_ACTIVE_LOW  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_blank_leading_zeros,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  output logic [6:0]              o_segments,
  output logic [NUM_DIGITS-1:0]   o_digit_enable
);

  localparam int INDEX_WIDTH = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_WIDTH = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [BLINK_WIDTH-1:0] BLINK_LAST = BLINK_WIDTH'(BLINK_CYCLES - 1);
  localparam logic                   SEG_LOW    = (SEG_ACTIVE_LOW != 0);
  localparam logic                   EN_LOW     = (EN_ACTIVE_LOW != 0);
  localparam logic [6:0]             SEG_IDLE   = seg_off(SEG_LOW);
  localparam logic [NUM_DIGITS-1:0]  EN_IDLE    = EN_LOW ? '1 : '0;

  scan_state_t             next_state;
  logic [INDEX_WIDTH-1:0]  next_index;
  logic                    frame_boundary;

  logic [4*NUM_DIGITS-1:0] displayed;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] display_next;
  logic [BLINK_WIDTH-1:0]  blink_count;
  logic                    blink_phase;
  logic                    blink_wrap;
  logic                    blink_phase_next;
  logic [NUM_DIGITS-1:0]   digit_onehot;
  logic [NUM_DIGITS-1:0]   zero_mask;
  logic                    upper_zero;
  logic [3:0]              nibble;
  logic                    zero_blank;
  logic                    blink_blank;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   en_next;

  seven_segment_scan_timer #(
    .NUM_DIGITS     (NUM_DIGITS),
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .DEAD_CYCLES    (DEAD_CYCLES),
    .INDEX_WIDTH    (INDEX_WIDTH)
  ) scan_timer (
    .clk            (i_clk),
    .rst            (i_reset),
    .next_state     (next_state),
    .next_index     (next_index),
    .frame_boundary (frame_boundary)
  );

  // Work out what the output registers will hold after this edge: value, blink phase, glyph and enable.
  always_comb begin
    display_next = (frame_boundary && !o_ready) ? pending : displayed;

    blink_wrap       = (blink_count == BLINK_LAST);
    blink_phase_next = blink_wrap ? ~blink_phase : blink_phase;

    digit_onehot = '0;
    nibble       = 4'h0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (next_index == INDEX_WIDTH'(d)) begin
        digit_onehot[d] = 1'b1;
        nibble          = display_next[4*d +: 4];
      end
    end

    upper_zero = 1'b1;
    zero_mask  = '0;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      upper_zero   = upper_zero & (display_next[4*d +: 4] == 4'h0);
      zero_mask[d] = upper_zero;
    end

    zero_blank  = i_blank_leading_zeros && |(digit_onehot & zero_mask);
    blink_blank = !blink_phase_next && |(digit_onehot & i_blink_mask);

    if ((next_state != DRIVE) || zero_blank || blink_blank) begin
      seg_next = SEG_IDLE;
    end else begin
      seg_next = seg_on(glyph(nibble), SEG_LOW);
    end

    if (next_state == DRIVE) begin
      en_next = EN_LOW ? ~digit_onehot : digit_onehot;
    end else begin
      en_next = EN_IDLE;
    end
  end

  // Handshake, displayed value, blink timebase and the registered pin drivers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      displayed      <= '0;
      pending        <= '0;
      o_ready        <= 1'b1;
      blink_count    <= '0;
      blink_phase    <= 1'b1;
      o_segments     <= SEG_IDLE;
      o_digit_enable <= EN_IDLE;
    end else begin
      displayed <= display_next;
      if (frame_boundary && !o_ready) begin
        o_ready <= 1'b1;
      end else if (i_valid && o_ready) begin
        pending <= i_value;
        o_ready <= 1'b0;
      end
      blink_count    <= blink_wrap ? '0 : blink_count + 1'b1;
      blink_phase    <= blink_phase_next;
      o_segments     <= seg_next;
      o_digit_enable <= en_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux: an active-low and an active-high
// segment instance share stimulus; a cycle model predicts every output.
module tb_seven_segment_mux;

  localparam int N     = 4;
  localparam int R     = 3;
  localparam int D     = 1;
  localparam int B     = 20;
  localparam int FRAME = N * (R + D);

  typedef struct packed {
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;
    logic [3:0] en;
    logic       ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_value;
  logic        i_valid;
  logic        i_blz;
  logic [3:0]  i_mask;
  logic        ready_lo, ready_hi;
  logic [6:0]  seg_lo, seg_hi;
  logic [3:0]  en_lo, en_hi;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic [15:0] stim_value = 16'h0;
  logic        stim_valid = 1'b0;
  logic        stim_blz   = 1'b0;
  logic [3:0]  stim_mask  = 4'h0;

  int          mk;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_full;

  logic [6:0] gl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  seven_segment_mux #(
    .NUM_DIGITS(N), .REFRESH_CYCLES(R), .DEAD_CYCLES(D), .BLINK_CYCLES(B),
    .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)
  ) dut_lo (
    .i_clk(clk), .i_reset(rst), .i_value(i_value), .i_valid(i_valid),
    .o_ready(ready_lo), .i_blank_leading_zeros(i_blz), .i_blink_mask(i_mask),
    .o_segments(seg_lo), .o_digit_enable(en_lo)
  );

  seven_segment_mux #(
    .NUM_DIGITS(N), .REFRESH_CYCLES(R), .DEAD_CYCLES(D), .BLINK_CYCLES(B),
    .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(1)
  ) dut_hi (
    .i_clk(clk), .i_reset(rst), .i_value(i_value), .i_valid(i_valid),
    .o_ready(ready_hi), .i_blank_leading_zeros(i_blz), .i_blink_mask(i_mask),
    .o_segments(seg_hi), .o_digit_enable(en_hi)
  );

  task automatic compare(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive the held stimulus and push the model's prediction for the coming edge.
  task automatic applyStimulus();
    exp_t       e;
    int         kn, p, slot;
    logic       drive, boundary, phase_on, zblank, bblank;
    logic [6:0] ah;
    i_value = stim_value;
    i_valid = stim_valid;
    i_blz   = stim_blz;
    i_mask  = stim_mask;
    kn       = mk + 1;
    p        = (kn - 1) % FRAME;
    slot     = p / (R + D);
    drive    = (p % (R + D)) < R;
    boundary = (p == 0);
    if (boundary && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (stim_valid && !m_full) begin
      m_pend = stim_value;
      m_full = 1'b1;
    end
    phase_on = ((kn / B) % 2) == 0;
    ah = 7'h00;
    if (drive) begin
      zblank = stim_blz && (slot >= 1) && ((m_disp >> (4 * slot)) == 16'h0);
      bblank = stim_mask[slot] && !phase_on;
      if (!zblank && !bblank) ah = gl[m_disp[4*slot +: 4]];
    end
    e.seg_hi = ah;
    e.seg_lo = ~ah;
    e.en     = drive ? ~(4'b0001 << slot) : 4'hF;
    e.ready  = !m_full;
    sb.push_back(e);
    mk = kn;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare("sb_seg_lo", {9'h0, seg_lo}, {9'h0, e.seg_lo});
      compare("sb_seg_hi", {9'h0, seg_hi}, {9'h0, e.seg_hi});
      compare("sb_en_lo", {12'h0, en_lo}, {12'h0, e.en});
      compare("sb_en_hi", {12'h0, en_hi}, {12'h0, e.en});
      compare("sb_ready_lo", {15'h0, ready_lo}, {15'h0, e.ready});
      compare("sb_ready_hi", {15'h0, ready_hi}, {15'h0, e.ready});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    applyStimulus();
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst    = 1'b0;
    mk     = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_full = 1'b0;
    sb.delete();
    applyStimulus();
  endtask

  task automatic waitEnable(input logic [3:0] pat, input string tag);
    int n = 0;
    while (en_lo !== pat && n < 40) begin
      tick();
      n++;
    end
    compare(tag, {12'h0, en_lo}, {12'h0, pat});
  endtask

  task automatic waitReady(input logic val, input string tag);
    int n = 0;
    while (ready_lo !== val && n < 60) begin
      tick();
      n++;
    end
    compare(tag, {15'h0, ready_lo}, {15'h0, val});
  endtask

  task automatic checkDigit(input int d, input logic [6:0] lo, input logic [6:0] hi);
    logic [3:0] pat;
    pat = ~(4'b0001 << d);
    waitEnable(pat, "digit_slot");
    compare($sformatf("digit%0d_seg_lo", d), {9'h0, seg_lo}, {9'h0, lo});
    compare($sformatf("digit%0d_seg_hi", d), {9'h0, seg_hi}, {9'h0, hi});
  endtask

  task automatic loadValue(input logic [15:0] v);
    stim_value = v;
    stim_valid = 1'b1;
    waitReady(1'b0, "load_accept");
    stim_valid = 1'b0;
    waitReady(1'b1, "load_boundary");
  endtask

  initial begin
    logic saw_off, saw_on;
    rst     = 1'b1;
    i_value = 16'h0;
    i_valid = 1'b0;
    i_blz   = 1'b0;
    i_mask  = 4'h0;
    mk      = 0;
    m_disp  = 16'h0;
    m_pend  = 16'h0;
    m_full  = 1'b0;
    repeat (2) @(negedge clk);
    compare("reset_ready", {15'h0, ready_lo}, 16'h1);
    compare("reset_seg_lo", {9'h0, seg_lo}, 16'h7F);
    compare("reset_seg_hi", {9'h0, seg_hi}, 16'h00);
    compare("reset_en", {12'h0, en_lo}, 16'hF);

    releaseReset();
    checkDigit(0, 7'h40, 7'h3F);
    repeat (FRAME) tick();
    checkDigit(2, 7'h40, 7'h3F);

    waitEnable(4'b1110, "sync_frame");
    stim_value = 16'h12AF;
    stim_valid = 1'b1;
    tick();
    stim_value = 16'hFFFF;
    tick();
    compare("ready_low_after_load", {15'h0, ready_lo}, 16'h0);
    tick();
    stim_valid = 1'b0;
    checkDigit(1, 7'h40, 7'h3F);
    waitReady(1'b1, "ready_at_boundary");
    checkDigit(0, 7'h0E, 7'h71);
    checkDigit(1, 7'h08, 7'h77);
    checkDigit(2, 7'h24, 7'h5B);
    checkDigit(3, 7'h79, 7'h06);

    loadValue(16'hFFFF);
    checkDigit(0, 7'h0E, 7'h71);
    checkDigit(3, 7'h0E, 7'h71);

    stim_blz = 1'b1;
    loadValue(16'h0050);
    checkDigit(0, 7'h40, 7'h3F);
    checkDigit(1, 7'h12, 7'h6D);
    checkDigit(2, 7'h7F, 7'h00);
    checkDigit(3, 7'h7F, 7'h00);

    loadValue(16'h0000);
    checkDigit(0, 7'h40, 7'h3F);
    checkDigit(1, 7'h7F, 7'h00);
    checkDigit(2, 7'h7F, 7'h00);
    checkDigit(3, 7'h7F, 7'h00);

    stim_mask = 4'b0001;
    saw_off = 1'b0;
    saw_on  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (en_lo === 4'b1110 && seg_lo === 7'h7F) saw_off = 1'b1;
      if (en_lo === 4'b1110 && seg_lo === 7'h40) saw_on = 1'b1;
    end
    compare("blink_saw_off", {15'h0, saw_off}, 16'h1);
    compare("blink_saw_on", {15'h0, saw_on}, 16'h1);
    stim_mask = 4'h0;
    stim_blz  = 1'b0;

    waitEnable(4'b1110, "sync_before_reset");
    stim_value = 16'h3333;
    stim_valid = 1'b1;
    tick();
    stim_valid = 1'b0;
    waitEnable(4'b1011, "mid_drive_digit2");
    compare("pending_before_reset", {15'h0, ready_lo}, 16'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    compare("async_seg_lo", {9'h0, seg_lo}, 16'h7F);
    compare("async_seg_hi", {9'h0, seg_hi}, 16'h00);
    compare("async_en", {12'h0, en_lo}, 16'hF);
    compare("async_ready", {15'h0, ready_lo}, 16'h1);
    sb.delete();
    repeat (2) @(negedge clk);
    releaseReset();
    checkDigit(0, 7'h40, 7'h3F);
    checkDigit(1, 7'h40, 7'h3F);
    compare("ready_after_reset", {15'h0, ready_lo}, 16'h1);
    repeat (FRAME + 4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
